// File: rtl/game_frame_sequencer_if.sv
// Handshake/bus bundle for game_frame_sequencer: frame trigger, key input,
// collision handshake and the per-frame update strobes.
interface game_frame_sequencer_if;
    logic       vblank_start;
    logic       key_valid;
    logic [7:0] key_code;
    logic [1:0] paddle_dx;
    logic [1:0] paddle_dy;
    logic       paddle_step;
    logic       ball_step;
    logic       collide_req;
    logic       collide_done;
    logic       goal_hit;
    logic       win_cond;
    logic       score_inc;
    logic       score_clr;
    logic       pos_reset;
    logic       win_active;
    logic       busy;
    logic       overrun;
    logic       coll_err;

    modport master (
        input  vblank_start, key_valid, key_code, collide_done, goal_hit, win_cond,
        output paddle_dx, paddle_dy, paddle_step, ball_step, collide_req,
               score_inc, score_clr, pos_reset, win_active, busy, overrun, coll_err
    );

    modport slave (
        output vblank_start, key_valid, key_code, collide_done, goal_hit, win_cond,
        input  paddle_dx, paddle_dy, paddle_step, ball_step, collide_req,
               score_inc, score_clr, pos_reset, win_active, busy, overrun, coll_err
    );
endinterface

// File: rtl/game_frame_sequencer.sv
// Once-per-frame scheduler: paddle, ball, collision, scoring, win-screen hold.
// Optional pause key (scan code 0x4D) is compiled in with `define GAME_PAUSE_EN.
module game_frame_sequencer #(
    parameter int unsigned PADDLE_DIV   = 1,
    parameter int unsigned BALL_DIV     = 2,
    parameter int unsigned WIN_FRAMES   = 180,
    parameter int unsigned COLL_TIMEOUT = 255
) (
    input  logic                   sysclk,
    input  logic                   rst,
    game_frame_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_PADDLE, S_BALL, S_COLLIDE, S_SCORE, S_WIN
    } state_t;

    localparam int unsigned WIN_W = $clog2(WIN_FRAMES + 1);
    localparam int unsigned TO_W  = $clog2(COLL_TIMEOUT + 1);

    state_t           r_state;
    logic [7:0]       r_pdiv;
    logic [7:0]       r_bdiv;
    logic [TO_W-1:0]  r_wait;
    logic [WIN_W-1:0] r_wcnt;
    logic [1:0]       r_dx;
    logic [1:0]       r_dy;
    logic             r_pend_valid;
    logic [7:0]       r_pend_code;
    logic             r_paddle_step;
    logic             r_ball_step;
    logic             r_collide_req;
    logic             r_score_inc;
    logic             r_score_clr;
    logic             r_pos_reset;
    logic             r_win_active;
    logic             r_busy;
    logic             r_overrun;
    logic             r_coll_err;
`ifdef GAME_PAUSE_EN
    logic             r_paused;
`endif

    logic       w_key_in;
    logic       w_apply;
    logic       w_frame_go;
    logic [7:0] w_code;
    logic [1:0] w_dx;
    logic [1:0] w_dy;

    function automatic logic is_move_key(input logic [7:0] c);
        return (c == 8'h1C) || (c == 8'h23) || (c == 8'h1D) || (c == 8'h1B) || (c == 8'hF0);
    endfunction

    // A fresh key in IDLE outranks whatever was parked during the sequence.
    always_comb begin
        w_key_in = bus.key_valid && is_move_key(bus.key_code);
        w_code   = w_key_in ? bus.key_code : r_pend_code;
        w_apply  = (r_state == S_IDLE) && !r_win_active && (w_key_in || r_pend_valid);
        w_dx     = r_dx;
        w_dy     = r_dy;
        case (w_code)
            8'h1C:   w_dx = 2'b11;
            8'h23:   w_dx = 2'b01;
            8'h1D:   w_dy = 2'b11;
            8'h1B:   w_dy = 2'b01;
            8'hF0:   begin w_dx = 2'b00; w_dy = 2'b00; end
            default: ;
        endcase
`ifdef GAME_PAUSE_EN
        w_frame_go = !r_paused;
`else
        w_frame_go = 1'b1;
`endif
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_pdiv        <= '0;
            r_bdiv        <= '0;
            r_wait        <= '0;
            r_wcnt        <= '0;
            r_dx          <= '0;
            r_dy          <= '0;
            r_pend_valid  <= 1'b0;
            r_pend_code   <= '0;
            r_paddle_step <= 1'b0;
            r_ball_step   <= 1'b0;
            r_collide_req <= 1'b0;
            r_score_inc   <= 1'b0;
            r_score_clr   <= 1'b0;
            r_pos_reset   <= 1'b0;
            r_win_active  <= 1'b0;
            r_busy        <= 1'b0;
            r_overrun     <= 1'b0;
            r_coll_err    <= 1'b0;
`ifdef GAME_PAUSE_EN
            r_paused      <= 1'b0;
`endif
        end else begin
            r_paddle_step <= 1'b0;
            r_ball_step   <= 1'b0;
            r_score_inc   <= 1'b0;
            r_score_clr   <= 1'b0;
            r_pos_reset   <= 1'b0;

            if (bus.vblank_start && (r_state != S_IDLE))
                r_overrun <= 1'b1;

            if (w_apply) begin
                r_dx <= w_dx;
                r_dy <= w_dy;
            end
            if (r_state == S_IDLE) begin
                r_pend_valid <= 1'b0;
            end else if (w_key_in && !r_win_active) begin
                r_pend_valid <= 1'b1;
                r_pend_code  <= bus.key_code;
            end
`ifdef GAME_PAUSE_EN
            if (bus.key_valid && (bus.key_code == 8'h4D) && !r_win_active)
                r_paused <= !r_paused;
`endif

            // Strobes are registered on entry, so each is high during its own state.
            case (r_state)
                S_IDLE: begin
                    if (bus.vblank_start) begin
                        if (r_win_active) begin
                            r_state <= S_WIN;
                            r_busy  <= 1'b1;
                            if (r_wcnt == WIN_W'(WIN_FRAMES - 1)) begin
                                r_pos_reset <= 1'b1;
                                r_score_clr <= 1'b1;
                                r_wcnt      <= '0;
                            end else begin
                                r_wcnt <= r_wcnt + WIN_W'(1);
                            end
                        end else if (w_frame_go) begin
                            r_state       <= S_PADDLE;
                            r_busy        <= 1'b1;
                            r_paddle_step <= (r_pdiv == 8'(PADDLE_DIV - 1));
                            r_pdiv        <= (r_pdiv == 8'(PADDLE_DIV - 1)) ? 8'd0 : r_pdiv + 8'd1;
                        end
                    end
                end
                S_PADDLE: begin
                    r_state     <= S_BALL;
                    r_ball_step <= (r_bdiv == 8'(BALL_DIV - 1));
                    r_bdiv      <= (r_bdiv == 8'(BALL_DIV - 1)) ? 8'd0 : r_bdiv + 8'd1;
                end
                S_BALL: begin
                    r_state       <= S_COLLIDE;
                    r_collide_req <= 1'b1;
                    r_wait        <= '0;
                end
                S_COLLIDE: begin
                    if (bus.collide_done) begin
                        r_state       <= S_SCORE;
                        r_collide_req <= 1'b0;
                        r_score_inc   <= bus.goal_hit;
                        r_pos_reset   <= bus.goal_hit;
                        if (bus.goal_hit && bus.win_cond) begin
                            r_win_active <= 1'b1;
                            r_dx         <= '0;
                            r_dy         <= '0;
                            r_pend_valid <= 1'b0;
                        end
                    end else if (r_wait == TO_W'(COLL_TIMEOUT - 1)) begin
                        r_state       <= S_IDLE;
                        r_busy        <= 1'b0;
                        r_collide_req <= 1'b0;
                        r_coll_err    <= 1'b1;
                    end else begin
                        r_wait <= r_wait + TO_W'(1);
                    end
                end
                S_SCORE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                S_WIN: begin
                    if (r_score_clr)
                        r_win_active <= 1'b0;
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.paddle_dx   = r_dx;
    assign bus.paddle_dy   = r_dy;
    assign bus.paddle_step = r_paddle_step;
    assign bus.ball_step   = r_ball_step;
    assign bus.collide_req = r_collide_req;
    assign bus.score_inc   = r_score_inc;
    assign bus.score_clr   = r_score_clr;
    assign bus.pos_reset   = r_pos_reset;
    assign bus.win_active  = r_win_active;
    assign bus.busy        = r_busy;
    assign bus.overrun     = r_overrun;
    assign bus.coll_err    = r_coll_err;
endmodule

// File: tb/tb_game_frame_sequencer.sv
// Self-checking bench for game_frame_sequencer against a frame-level model.
module tb_game_frame_sequencer;
    localparam int unsigned P_DIV = 1;
    localparam int unsigned B_DIV = 2;
    localparam int unsigned W_FR  = 180;
    localparam int unsigned C_TO  = 255;

    logic sysclk = 1'b0;
    logic rst    = 1'b1;

    game_frame_sequencer_if bus();

    game_frame_sequencer #(
        .PADDLE_DIV  (P_DIV),
        .BALL_DIV    (B_DIV),
        .WIN_FRAMES  (W_FR),
        .COLL_TIMEOUT(C_TO)
    ) dut (
        .sysclk(sysclk),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 sysclk = ~sysclk;

    int vec = 0;
    int err = 0;

    // Frame-level model: velocities as integers, frame counts, one parked key.
    int m_dx, m_dy, pend, pframes, bframes;
    bit m_win;
    logic [7:0] codes [8] = '{8'h1C, 8'h23, 8'h1D, 8'h1B, 8'hF0, 8'h4D, 8'h12, 8'h5A};

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic model_reset();
        m_dx = 0; m_dy = 0; pend = -1; pframes = 0; bframes = 0; m_win = 0;
    endtask

    function automatic bit recognised(input logic [7:0] c);
        return c inside {8'h1C, 8'h23, 8'h1D, 8'h1B, 8'hF0};
    endfunction

    task automatic model_apply(input logic [7:0] c);
        case (c)
            8'h1C: m_dx = -1;
            8'h23: m_dx = 1;
            8'h1D: m_dy = -1;
            8'h1B: m_dy = 1;
            8'hF0: begin m_dx = 0; m_dy = 0; end
            default: ;
        endcase
    endtask

    task automatic idle_key(input logic [7:0] c);
        bus.key_valid = 1'b1; bus.key_code = c;
        tick();
        bus.key_valid = 1'b0;
        if (!m_win) model_apply(c);
        vec++; if (bus.paddle_dx !== 2'(m_dx)) begin err++; $display("FAIL idle_key_dx code=%h: got %0d want %0d", c, $signed(bus.paddle_dx), m_dx); end
        vec++; if (bus.paddle_dy !== 2'(m_dy)) begin err++; $display("FAIL idle_key_dy code=%h: got %0d want %0d", c, $signed(bus.paddle_dy), m_dy); end
    endtask

    // One non-win frame; d = COLLIDE cycles before collide_done, keys at positions kp1/kp2 (0 = none).
    task automatic run_frame(input int d, input bit g, input bit w,
                             input int kp1, input logic [7:0] kc1,
                             input int kp2, input logic [7:0] kc2);
        bit ep, eb;
        logic [7:0] kc;
        pframes++; bframes++;
        ep = (pframes % P_DIV) == 0;
        eb = (bframes % B_DIV) == 0;
        bus.vblank_start = 1'b1;
        tick();
        bus.vblank_start = 1'b0;
        for (int pos = 1; pos <= 4 + d; pos++) begin
            if (pos == 4 + d && g && w) begin
                m_win = 1; m_dx = 0; m_dy = 0; pend = -1;
            end
            vec++; if (bus.paddle_dx !== 2'(m_dx) || bus.paddle_dy !== 2'(m_dy)) begin err++; $display("FAIL vel_stable pos=%0d: got %0d/%0d want %0d/%0d", pos, $signed(bus.paddle_dx), $signed(bus.paddle_dy), m_dx, m_dy); end
            vec++; if (bus.busy !== 1'b1) begin err++; $display("FAIL busy_seq pos=%0d: got %b want 1", pos, bus.busy); end
            if (pos == 1) begin
                vec++; if (bus.paddle_step !== ep) begin err++; $display("FAIL paddle_step frame=%0d: got %b want %b", pframes, bus.paddle_step, ep); end
            end else begin
                vec++; if (bus.paddle_step !== 1'b0) begin err++; $display("FAIL paddle_step_extra pos=%0d: got %b want 0", pos, bus.paddle_step); end
            end
            vec++; if (bus.ball_step !== ((pos == 2) ? eb : 1'b0)) begin err++; $display("FAIL ball_step pos=%0d frame=%0d: got %b want %b", pos, bframes, bus.ball_step, (pos == 2) ? eb : 1'b0); end
            vec++; if (bus.collide_req !== (pos >= 3 && pos <= 3 + d)) begin err++; $display("FAIL collide_req pos=%0d: got %b want %b", pos, bus.collide_req, (pos >= 3 && pos <= 3 + d)); end
            if (pos == 4 + d) begin
                vec++; if (bus.score_inc !== g || bus.pos_reset !== g) begin err++; $display("FAIL score_pulse: got inc=%b rst=%b want %b", bus.score_inc, bus.pos_reset, g); end
                vec++; if (bus.win_active !== m_win) begin err++; $display("FAIL win_set: got %b want %b", bus.win_active, m_win); end
            end else begin
                vec++; if (bus.score_inc !== 1'b0 || bus.pos_reset !== 1'b0) begin err++; $display("FAIL score_early pos=%0d: got inc=%b rst=%b want 0", pos, bus.score_inc, bus.pos_reset); end
            end
            if (pos == 3 + d) begin
                bus.collide_done = 1'b1; bus.goal_hit = g; bus.win_cond = w;
            end
            if (pos == kp2 || pos == kp1) begin
                kc = (pos == kp2) ? kc2 : kc1;
                bus.key_valid = 1'b1; bus.key_code = kc;
                if (!m_win && recognised(kc)) pend = kc;
            end
            tick();
            bus.collide_done = 1'b0; bus.goal_hit = 1'b0; bus.win_cond = 1'b0; bus.key_valid = 1'b0;
        end
        vec++; if (bus.busy !== 1'b0) begin err++; $display("FAIL busy_end: got %b want 0", bus.busy); end
        vec++; if (bus.score_inc !== 1'b0 || bus.pos_reset !== 1'b0) begin err++; $display("FAIL pulse_width: got inc=%b rst=%b want 0", bus.score_inc, bus.pos_reset); end
        vec++; if (bus.win_active !== m_win) begin err++; $display("FAIL win_hold: got %b want %b", bus.win_active, m_win); end
        if (pend >= 0 && !m_win) model_apply(8'(pend));
        pend = -1;
        tick();
        vec++; if (bus.paddle_dx !== 2'(m_dx) || bus.paddle_dy !== 2'(m_dy)) begin err++; $display("FAIL vel_after: got %0d/%0d want %0d/%0d", $signed(bus.paddle_dx), $signed(bus.paddle_dy), m_dx, m_dy); end
    endtask

    task automatic test_reset();
        bus.vblank_start = 0; bus.key_valid = 0; bus.key_code = 0;
        bus.collide_done = 0; bus.goal_hit = 0; bus.win_cond = 0;
        rst = 1'b1;
        tick(); tick();
        model_reset();
        vec++; if ({bus.paddle_dx, bus.paddle_dy, bus.paddle_step, bus.ball_step, bus.collide_req, bus.score_inc, bus.score_clr, bus.pos_reset, bus.win_active, bus.busy, bus.overrun, bus.coll_err} !== 14'd0) begin
            err++; $display("FAIL reset_outputs: got %b want 0", {bus.paddle_dx, bus.paddle_dy, bus.paddle_step, bus.ball_step, bus.collide_req, bus.score_inc, bus.score_clr, bus.pos_reset, bus.win_active, bus.busy, bus.overrun, bus.coll_err});
        end
        rst = 1'b0;
        tick();
        vec++; if (bus.busy !== 1'b0) begin err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_first_frames();
        idle_key(8'h23);
        run_frame(2, 0, 0, 0, 8'h00, 0, 8'h00);
        run_frame(0, 0, 0, 0, 8'h00, 0, 8'h00);
    endtask

    task automatic test_goal();
        run_frame(1, 1, 0, 0, 8'h00, 0, 8'h00);
    endtask

    task automatic test_pending_key();
        run_frame(1, 0, 0, 2, 8'h1C, 3, 8'hF0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            int d, kp1, kp2;
            bit g, w;
            if ($urandom_range(0, 1) == 1) idle_key(codes[$urandom_range(0, 7)]);
            d   = $urandom_range(0, 4);
            g   = ($urandom_range(0, 3) == 0);
            w   = g ? 1'b0 : 1'($urandom_range(0, 1));
            kp1 = $urandom_range(0, 4 + d);
            kp2 = $urandom_range(0, 4 + d);
            run_frame(d, g, w, kp1, codes[$urandom_range(0, 7)], kp2, codes[$urandom_range(0, 7)]);
        end
    endtask

    task automatic test_timeout_overrun();
        int cnt;
        bit ep, eb, saw_inc;
        vec++; if (bus.coll_err !== 1'b0 || bus.overrun !== 1'b0) begin err++; $display("FAIL sticky_pre: got err=%b ovr=%b want 0", bus.coll_err, bus.overrun); end
        pframes++; bframes++;
        ep = (pframes % P_DIV) == 0;
        eb = (bframes % B_DIV) == 0;
        bus.vblank_start = 1'b1; tick(); bus.vblank_start = 1'b0;
        vec++; if (bus.paddle_step !== ep) begin err++; $display("FAIL to_paddle: got %b want %b", bus.paddle_step, ep); end
        tick();
        vec++; if (bus.ball_step !== eb) begin err++; $display("FAIL to_ball: got %b want %b", bus.ball_step, eb); end
        tick();
        cnt = 0; saw_inc = 0;
        while (bus.collide_req === 1'b1 && cnt < int'(C_TO) + 20) begin
            cnt++;
            if (bus.score_inc !== 1'b0) saw_inc = 1;
            tick();
        end
        vec++; if (cnt != int'(C_TO)) begin err++; $display("FAIL to_req_cycles: got %0d want %0d", cnt, C_TO); end
        vec++; if (bus.coll_err !== 1'b1) begin err++; $display("FAIL coll_err: got %b want 1", bus.coll_err); end
        vec++; if (bus.busy !== 1'b0) begin err++; $display("FAIL to_idle: got %b want 0", bus.busy); end
        vec++; if (saw_inc || bus.score_inc !== 1'b0) begin err++; $display("FAIL to_score_inc: got %b want 0", saw_inc | bus.score_inc); end
        tick();
        pframes++; bframes++;
        eb = (bframes % B_DIV) == 0;
        bus.vblank_start = 1'b1; tick(); bus.vblank_start = 1'b0;
        tick();
        vec++; if (bus.ball_step !== eb) begin err++; $display("FAIL ovr_ball: got %b want %b", bus.ball_step, eb); end
        tick();
        bus.vblank_start = 1'b1; tick(); bus.vblank_start = 1'b0;
        vec++; if (bus.overrun !== 1'b1) begin err++; $display("FAIL overrun: got %b want 1", bus.overrun); end
        vec++; if (bus.collide_req !== 1'b1 || bus.paddle_step !== 1'b0) begin err++; $display("FAIL ovr_no_restart: got req=%b pstep=%b want 1/0", bus.collide_req, bus.paddle_step); end
        bus.collide_done = 1'b1; tick(); bus.collide_done = 1'b0;
        vec++; if (bus.busy !== 1'b1 || bus.score_inc !== 1'b0) begin err++; $display("FAIL ovr_score: got busy=%b inc=%b want 1/0", bus.busy, bus.score_inc); end
        tick();
        vec++; if (bus.busy !== 1'b0 || bus.coll_err !== 1'b1) begin err++; $display("FAIL ovr_end: got busy=%b err=%b want 0/1", bus.busy, bus.coll_err); end
    endtask

    task automatic test_win();
        run_frame(1, 1, 1, 2, 8'h23, 0, 8'h00);
        for (int i = 1; i <= int'(W_FR); i++) begin
            bus.vblank_start = 1'b1; bus.key_valid = 1'b1; bus.key_code = 8'h1D;
            tick();
            bus.vblank_start = 1'b0; bus.key_valid = 1'b0;
            vec++; if (bus.paddle_step !== 1'b0 || bus.busy !== 1'b1) begin err++; $display("FAIL win_frame%0d: got pstep=%b busy=%b want 0/1", i, bus.paddle_step, bus.busy); end
            vec++; if (bus.score_clr !== (i == int'(W_FR)) || bus.pos_reset !== (i == int'(W_FR))) begin err++; $display("FAIL win_clr%0d: got clr=%b rst=%b want %b", i, bus.score_clr, bus.pos_reset, i == int'(W_FR)); end
            tick();
            vec++; if (bus.ball_step !== 1'b0 || bus.collide_req !== 1'b0 || bus.busy !== 1'b0) begin err++; $display("FAIL win_quiet%0d: got b=%b r=%b busy=%b want 0", i, bus.ball_step, bus.collide_req, bus.busy); end
            vec++; if (bus.win_active !== (i != int'(W_FR))) begin err++; $display("FAIL win_active%0d: got %b want %b", i, bus.win_active, i != int'(W_FR)); end
            vec++; if (bus.paddle_dy !== 2'(m_dy) || bus.paddle_dx !== 2'(m_dx)) begin err++; $display("FAIL win_keys%0d: got %0d/%0d want %0d/%0d", i, $signed(bus.paddle_dx), $signed(bus.paddle_dy), m_dx, m_dy); end
        end
        m_win = 0;
        run_frame(0, 0, 0, 1, 8'h1B, 0, 8'h00);
    endtask

    task automatic test_mid_reset();
        bus.vblank_start = 1'b1; tick(); bus.vblank_start = 1'b0;
        tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        model_reset();
        vec++; if ({bus.paddle_dx, bus.paddle_dy, bus.paddle_step, bus.ball_step, bus.collide_req, bus.score_inc, bus.score_clr, bus.pos_reset, bus.win_active, bus.busy, bus.overrun, bus.coll_err} !== 14'd0) begin
            err++; $display("FAIL midreset_outputs: got %b want 0", {bus.paddle_dx, bus.paddle_dy, bus.paddle_step, bus.ball_step, bus.collide_req, bus.score_inc, bus.score_clr, bus.pos_reset, bus.win_active, bus.busy, bus.overrun, bus.coll_err});
        end
        run_frame(1, 0, 0, 0, 8'h00, 0, 8'h00);
    endtask

    initial begin
        test_reset();
        test_first_frames();
        test_goal();
        test_pending_key();
        test_random();
        test_timeout_overrun();
        test_win();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end
endmodule
